// File: rtl/riscv_pkg.sv
// Shared constants and scalar types for the RISC-V core datapath.
package riscv_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending tracker for the register file: one bit per register,
// set at issue, cleared at writeback, wiped on flush, plus operand-ready flags.
module regfile_scoreboard
   import riscv_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic              flush,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_ready,
   output logic [NREGS-1:0]  pend_vec
);

   logic [NREGS-1:0] pend_r;
   logic [NREGS-1:0] pend_nxt_s;

   // Next pending vector: writeback clear, then issue set, then flush override.
   always_comb begin
      pend_nxt_s = pend_r;
      for (int w = 0; w < NWR; w++) begin
         pend_nxt_s[wr_addr[w*AW +: AW]] =
            (wr_en[w] && (wr_addr[w*AW +: AW] != {AW{1'b0}})) ? 1'b0
                                                              : pend_nxt_s[wr_addr[w*AW +: AW]];
      end
      // A new producer supersedes one completing in the same cycle.
      pend_nxt_s[iss_rd] = (iss_valid && (iss_rd != {AW{1'b0}})) ? 1'b1 : pend_nxt_s[iss_rd];
      pend_nxt_s         = flush ? {NREGS{1'b0}} : pend_nxt_s;
      pend_nxt_s[0]      = 1'b0;
   end

   // Pending-bit register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r <= {NREGS{1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
      end
   end

   // Operand ready: x0, not pending, or the value arrives on a write port now.
   always_comb begin
      rd_ready = {NRD{1'b0}};
      for (int i = 0; i < NRD; i++) begin
         rd_ready[i] = (rd_addr[i*AW +: AW] == {AW{1'b0}}) | ~pend_r[rd_addr[i*AW +: AW]];
         for (int w = 0; w < NWR; w++) begin
            rd_ready[i] = rd_ready[i] |
                          (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW]));
         end
      end
   end

   assign pend_vec = pend_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass and a
// pending scoreboard so decode can stall on outstanding producers.
module regfile_mp
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_ready,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush,
   output logic [NREGS-1:0]    pend_vec
);

   logic [XLEN-1:0] regs_r [NREGS];
   logic [NWR-1:0]  wr_en_s;

   // Writes are ignored while in reset so the bypass cannot leak data out.
   assign wr_en_s = wr_en & {NWR{rst_n}};

   // Register array; later write ports overwrite earlier ones on a collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_r[r] <= {XLEN{1'b0}};
         end
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_en_s[w] && (wr_addr[w*AW +: AW] != {AW{1'b0}})) begin
               regs_r[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
         end
      end
   end

   // Read mux: array value, overridden by the highest matching write port, x0 forced to 0.
   always_comb begin
      rd_data = {(NRD*XLEN){1'b0}};
      for (int i = 0; i < NRD; i++) begin
         rd_data[i*XLEN +: XLEN] = regs_r[rd_addr[i*AW +: AW]];
         for (int w = 0; w < NWR; w++) begin
            rd_data[i*XLEN +: XLEN] =
               (wr_en_s[w] && (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW]))
                  ? wr_data[w*XLEN +: XLEN] : rd_data[i*XLEN +: XLEN];
         end
         rd_data[i*XLEN +: XLEN] = (rd_addr[i*AW +: AW] == {AW{1'b0}})
                                   ? {XLEN{1'b0}} : rd_data[i*XLEN +: XLEN];
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR),
      .AW    (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en_s),
      .wr_addr   (wr_addr),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .rd_addr   (rd_addr),
      .rd_ready  (rd_ready),
      .pend_vec  (pend_vec)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic checked against an array-based reference model.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_ready;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_valid;
   logic [AW-1:0]       iss_rd;
   logic                flush;
   logic [NREGS-1:0]    pend_vec;

   logic [XLEN-1:0]  m_regs [NREGS];
   logic [NREGS-1:0] m_pend;

   int n_cmp = 0;
   int n_err = 0;

   regfile_mp dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .pend_vec  (pend_vec)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      if (!rst_n || a == 5'd0) return 32'd0;
      v = m_regs[a];
      for (int w = 0; w < NWR; w++)
         if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*XLEN +: XLEN];
      return v;
   endfunction

   function automatic logic exp_ready(input logic [AW-1:0] a);
      if (!rst_n || a == 5'd0 || !m_pend[a]) return 1'b1;
      for (int w = 0; w < NWR; w++)
         if (wr_en[w] && wr_addr[w*AW +: AW] == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < NREGS; r++) m_regs[r] = 32'd0;
      m_pend = 32'd0;
   endtask

   task automatic idle();
      wr_en     = 2'b00;
      iss_valid = 1'b0;
      iss_rd    = 5'd0;
      flush     = 1'b0;
   endtask

   // One rising edge; the model applies the same inputs the DUT sampled.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != 5'd0) begin
               m_regs[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
               m_pend[wr_addr[w*AW +: AW]] = 1'b0;
            end
         end
         if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
         if (flush) m_pend = 32'd0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      idle();
      rd_addr = {5'd13, 5'd21};
      wr_en   = 2'b11;
      wr_addr = {5'd13, 5'd21};
      wr_data = {32'hCAFE_F00D, 32'h1357_9BDF};
      #1;
      n_cmp++;
      if (rd_data !== 64'd0) begin
         n_err++;
         $display("FAIL reset_rd_data: got %h expected 0", rd_data);
      end
      n_cmp++;
      if (rd_ready !== 2'b11) begin
         n_err++;
         $display("FAIL reset_rd_ready: got %b expected 11", rd_ready);
      end
      tick();
      tick();
      n_cmp++;
      if (pend_vec !== 32'd0) begin
         n_err++;
         $display("FAIL reset_pend: got %h expected 0", pend_vec);
      end
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      rd_addr = {5'd0, 5'd5};
      #1;
      n_cmp++;
      if (rd_data[31:0] !== 32'd0) begin
         n_err++;
         $display("FAIL reset_read_x5: got %h expected 0", rd_data[31:0]);
      end
   endtask

   task automatic test_write_x0();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd7};
      wr_data = {32'd0, 32'hDEAD_BEEF};
      tick();
      idle();
      rd_addr = {5'd7, 5'd7};
      #1;
      n_cmp++;
      if (rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
         n_err++;
         $display("FAIL write_x7: got %h expected deadbeefdeadbeef", rd_data);
      end
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd0};
      wr_data = {32'd0, 32'h0000_1234};
      rd_addr = {5'd0, 5'd0};
      #1;
      n_cmp++;
      if (rd_data !== 64'd0 || rd_ready !== 2'b11) begin
         n_err++;
         $display("FAIL x0_bypass: got data %h ready %b expected 0 / 11", rd_data, rd_ready);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (rd_data[31:0] !== 32'd0) begin
         n_err++;
         $display("FAIL x0_read: got %h expected 0", rd_data[31:0]);
      end
   endtask

   task automatic test_bypass_priority();
      wr_en   = 2'b11;
      wr_addr = {5'd3, 5'd3};
      wr_data = {32'h0000_0022, 32'h0000_0011};
      rd_addr = {5'd7, 5'd3};
      #1;
      n_cmp++;
      if (rd_data[31:0] !== 32'h0000_0022) begin
         n_err++;
         $display("FAIL bypass_prio: got %h expected 22", rd_data[31:0]);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (rd_data[31:0] !== 32'h0000_0022) begin
         n_err++;
         $display("FAIL array_prio: got %h expected 22", rd_data[31:0]);
      end
   endtask

   task automatic test_scoreboard();
      iss_valid = 1'b1;
      iss_rd    = 5'd9;
      tick();
      idle();
      rd_addr = {5'd0, 5'd9};
      #1;
      n_cmp++;
      if (rd_ready[0] !== 1'b0 || pend_vec[9] !== 1'b1) begin
         n_err++;
         $display("FAIL sb_issue: got ready %b pend %b expected 0 / 1", rd_ready[0], pend_vec[9]);
      end
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd9};
      wr_data = {32'd0, 32'h0000_0055};
      #1;
      n_cmp++;
      if (rd_ready[0] !== 1'b1 || rd_data[31:0] !== 32'h0000_0055) begin
         n_err++;
         $display("FAIL sb_wb_bypass: got ready %b data %h expected 1 / 55", rd_ready[0], rd_data[31:0]);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (pend_vec[9] !== 1'b0) begin
         n_err++;
         $display("FAIL sb_clear: got %b expected 0", pend_vec[9]);
      end
   endtask

   task automatic test_simultaneous();
      iss_valid = 1'b1;
      iss_rd    = 5'd4;
      wr_en     = 2'b10;
      wr_addr   = {5'd4, 5'd0};
      wr_data   = {32'h0000_0444, 32'd0};
      tick();
      idle();
      #1;
      n_cmp++;
      if (pend_vec[4] !== 1'b1) begin
         n_err++;
         $display("FAIL issue_beats_write: got %b expected 1", pend_vec[4]);
      end
      iss_valid = 1'b1;
      iss_rd    = 5'd0;
      tick();
      idle();
      #1;
      n_cmp++;
      if (pend_vec[0] !== 1'b0) begin
         n_err++;
         $display("FAIL issue_x0: got %b expected 0", pend_vec[0]);
      end
      iss_valid = 1'b1;
      iss_rd    = 5'd6;
      flush     = 1'b1;
      tick();
      idle();
      #1;
      n_cmp++;
      if (pend_vec !== 32'd0) begin
         n_err++;
         $display("FAIL flush: got %h expected 0", pend_vec);
      end
   endtask

   task automatic test_async_reset();
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd2};
      wr_data = {32'd0, 32'hA5A5_A5A5};
      tick();
      idle();
      iss_valid = 1'b1;
      iss_rd    = 5'd2;
      tick();
      idle();
      rd_addr = {5'd0, 5'd2};
      #1;
      n_cmp++;
      if (rd_data[31:0] !== 32'hA5A5_A5A5 || pend_vec[2] !== 1'b1) begin
         n_err++;
         $display("FAIL async_pre: got data %h pend %b expected a5a5a5a5 / 1", rd_data[31:0], pend_vec[2]);
      end
      #1;
      rst_n = 1'b0;
      model_clear();
      #1;
      n_cmp++;
      if (rd_data[31:0] !== 32'd0 || pend_vec !== 32'd0 || rd_ready !== 2'b11) begin
         n_err++;
         $display("FAIL async_reset: got data %h pend %h ready %b expected 0 / 0 / 11",
                  rd_data[31:0], pend_vec, rd_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         for (int w = 0; w < NWR; w++) begin
            wr_addr[w*AW +: AW]   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                                : AW'($urandom_range(0, 7));
            wr_data[w*XLEN +: XLEN] = $urandom;
         end
         for (int i = 0; i < NRD; i++)
            rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
         wr_en     = NWR'($urandom_range(0, 3));
         iss_valid = ($urandom_range(0, 1) == 1);
         iss_rd    = AW'($urandom_range(0, 7));
         flush     = ($urandom_range(0, 15) == 0);
         #1;
         for (int i = 0; i < NRD; i++) begin
            n_cmp++;
            if (rd_data[i*XLEN +: XLEN] !== exp_rd(rd_addr[i*AW +: AW])) begin
               n_err++;
               $display("FAIL rand_rd_data[%0d] iter %0d: got %h expected %h", i, n,
                        rd_data[i*XLEN +: XLEN], exp_rd(rd_addr[i*AW +: AW]));
            end
            n_cmp++;
            if (rd_ready[i] !== exp_ready(rd_addr[i*AW +: AW])) begin
               n_err++;
               $display("FAIL rand_rd_ready[%0d] iter %0d: got %b expected %b", i, n,
                        rd_ready[i], exp_ready(rd_addr[i*AW +: AW]));
            end
         end
         n_cmp++;
         if (pend_vec !== m_pend) begin
            n_err++;
            $display("FAIL rand_pend iter %0d: got %h expected %h", n, pend_vec, m_pend);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_write_x0();
      test_bypass_priority();
      test_scoreboard();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
